// File: rtl/alarm_ringer.sv
// ============================================================================
// Module      : alarm_ringer
// Description : Alarm consumer. Compares the stored alarm time against the
//               running clock on each 1 Hz tick, rings the buzzer, and
//               handles stop, limited snooze and automatic ring timeout.
//
// Ports
//   Clk        in   system clock
//   RST        in   asynchronous reset, active-low
//   Tick       in   one-Clk-wide 1 Hz pulse
//   EN         in   alarm armed (level)
//   Mode       in   1 = 12 h (APM compared), 0 = 24 h (APM ignored)
//   Hour/Min/Sec  in  current time, BCD
//   APM        in   current AM/PM flag, 1 = PM
//   AlertHour/AlertMin/AlertAPM  in  stored alarm time
//   Stop       in   raw stop button (asynchronous)
//   Snooze     in   raw snooze button (asynchronous)
//   Ring       out  high while ringing
//   Beep       out  buzzer drive, Ring gated by a per-tick toggle
//   Snoozing   out  high while snoozing
//   SnzCnt     out  snoozes used in the current alarm event
//   Chime      out  hourly chime (0 unless the chime build option is set)
//
// Build option : `define ALARM_RINGER_HOURLY_CHIME_EN enables the hourly
//                chime; otherwise Chime is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_ringer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int CHIME_SECS  = 2
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       Tick,
  input  logic       EN,
  input  logic       Mode,
  input  logic [7:0] Hour,
  input  logic [7:0] Min,
  input  logic [7:0] Sec,
  input  logic       APM,
  input  logic [7:0] AlertHour,
  input  logic [7:0] AlertMin,
  input  logic       AlertAPM,
  input  logic       Stop,
  input  logic       Snooze,
  output logic       Ring,
  output logic       Beep,
  output logic       Snoozing,
  output logic [1:0] SnzCnt,
  output logic       Chime
);

  // Terminal counts compared on the tick that ends a ring / snooze period.
  localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
  localparam logic [1:0] MAX_SNZ     = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [1:0] snz_q, snz_d;
  logic       tog_q, tog_d;
  logic       ring_q, beep_q, snoozing_q;

  // Bits [1:0] form the 2-FF synchroniser, bit [2] holds the previous
  // synchronised value for the rising-edge detector.
  logic [2:0] stop_sync_q;
  logic [2:0] snz_sync_q;
  logic       stop_p, snz_p;
  logic       w_match;

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      stop_sync_q <= '0;
      snz_sync_q  <= '0;
    end else begin
      stop_sync_q <= {stop_sync_q[1:0], Stop};
      snz_sync_q  <= {snz_sync_q[1:0], Snooze};
    end
  end

  assign stop_p = stop_sync_q[1] & ~stop_sync_q[2];
  assign snz_p  = snz_sync_q[1]  & ~snz_sync_q[2];

  assign w_match = (Hour == AlertHour) && (Min == AlertMin) && (Sec == 8'h00) &&
                   (!Mode || (APM == AlertAPM));

  // Next-state logic. Priority: EN low > stop > snooze > tick events.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snz_d   = snz_q;
    tog_d   = tog_q;
    case (state_q)
      ST_IDLE: begin
        if (EN && Tick && w_match) begin
          state_d = ST_RINGING;
          cnt_d   = '0;
          snz_d   = '0;
          tog_d   = 1'b1;
        end
      end
      ST_RINGING: begin
        if (!EN || stop_p) begin
          state_d = ST_IDLE;
        end else if (snz_p) begin
          if (snz_q < MAX_SNZ) begin
            state_d = ST_SNOOZE;
            snz_d   = snz_q + 2'd1;
            cnt_d   = '0;
          end else begin
            // Snooze allowance exhausted: behaves as stop.
            state_d = ST_IDLE;
          end
        end else if (Tick) begin
          if (cnt_q == RING_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 9'd1;
            tog_d = ~tog_q;
          end
        end
      end
      ST_SNOOZE: begin
        // Snooze presses are ignored while already snoozing.
        if (!EN || stop_p) begin
          state_d = ST_IDLE;
        end else if (Tick) begin
          if (cnt_q == SNOOZE_LAST) begin
            state_d = ST_RINGING;
            cnt_d   = '0;
            tog_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      snz_q      <= '0;
      tog_q      <= 1'b0;
      ring_q     <= 1'b0;
      beep_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snz_q      <= snz_d;
      tog_q      <= tog_d;
      // Outputs are decoded from the next state so they line up with it.
      ring_q     <= (state_d == ST_RINGING);
      beep_q     <= (state_d == ST_RINGING) && tog_d;
      snoozing_q <= (state_d == ST_SNOOZE);
    end
  end

  assign Ring     = ring_q;
  assign Beep     = beep_q;
  assign Snoozing = snoozing_q;
  assign SnzCnt   = snz_q;

`ifdef ALARM_RINGER_HOURLY_CHIME_EN
  localparam logic [1:0] CHIME_LEN = 2'(CHIME_SECS);

  logic [1:0] chime_cnt_q, chime_cnt_d;
  logic       chime_q;

  // Chime counts remaining ticks. It is cleared whenever the FSM is (or is
  // about to be) outside IDLE, so an alarm on the same tick wins.
  always_comb begin
    chime_cnt_d = chime_cnt_q;
    if (state_d != ST_IDLE) begin
      chime_cnt_d = '0;
    end else if (Tick && (state_q == ST_IDLE) && (Min == 8'h00) && (Sec == 8'h00)) begin
      chime_cnt_d = CHIME_LEN;
    end else if (Tick && (chime_cnt_q != 2'd0)) begin
      chime_cnt_d = chime_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      chime_cnt_q <= '0;
      chime_q     <= 1'b0;
    end else begin
      chime_cnt_q <= chime_cnt_d;
      chime_q     <= (chime_cnt_d != 2'd0);
    end
  end

  assign Chime = chime_q;
`else
  assign Chime = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alarm_ringer.sv
`default_nettype none

module tb_alarm_ringer;

  logic       Clk = 1'b0;
  logic       RST = 1'b0;
  logic       Tick = 1'b0;
  logic       EN = 1'b1;
  logic       Mode = 1'b0;
  logic [7:0] Hour = 8'h07;
  logic [7:0] Min = 8'h29;
  logic [7:0] Sec = 8'h59;
  logic       APM = 1'b0;
  logic [7:0] AlertHour = 8'h07;
  logic [7:0] AlertMin = 8'h30;
  logic       AlertAPM = 1'b0;
  logic       Stop = 1'b0;
  logic       Snooze = 1'b0;
  logic       Ring, Beep, Snoozing, Chime;
  logic [1:0] SnzCnt;

`ifdef ALARM_RINGER_HOURLY_CHIME_EN
  localparam bit CHIME_ON = 1'b1;
`else
  localparam bit CHIME_ON = 1'b0;
`endif

  alarm_ringer dut (
    .Clk(Clk), .RST(RST), .Tick(Tick), .EN(EN), .Mode(Mode),
    .Hour(Hour), .Min(Min), .Sec(Sec), .APM(APM),
    .AlertHour(AlertHour), .AlertMin(AlertMin), .AlertAPM(AlertAPM),
    .Stop(Stop), .Snooze(Snooze),
    .Ring(Ring), .Beep(Beep), .Snoozing(Snoozing), .SnzCnt(SnzCnt), .Chime(Chime)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    string    nm;
    bit       ring;
    bit       beep;
    bit       snzg;
    bit [1:0] sc;
    bit       chime;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic compare(input string nm, input bit ring, input bit beep,
                         input bit snzg, input bit [1:0] sc, input bit chime);
    checks++;
    if (Ring !== ring || Beep !== beep || Snoozing !== snzg || SnzCnt !== sc || Chime !== chime) begin
      failures++;
      $display("FAIL %s @cyc %0d: got Ring=%b Beep=%b Snoozing=%b SnzCnt=%0d Chime=%b, want Ring=%b Beep=%b Snoozing=%b SnzCnt=%0d Chime=%b",
               nm, cyc, Ring, Beep, Snoozing, SnzCnt, Chime, ring, beep, snzg, sc, chime);
    end
  endtask

  // Monitor: compares queued expectations on the falling edge of their cycle.
  always @(negedge Clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: expectation for cyc %0d not checked (now %0d)", e.nm, e.cyc, cyc);
      end else begin
        compare(e.nm, e.ring, e.beep, e.snzg, e.sc, e.chime);
      end
    end
  end

  task automatic expect_at(input int c, input string nm, input bit ring, input bit beep,
                           input bit snzg, input bit [1:0] sc, input bit chime);
    exp_t e;
    e.cyc = c; e.nm = nm; e.ring = ring; e.beep = beep;
    e.snzg = snzg; e.sc = sc; e.chime = chime;
    sbq.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc1();
    @(posedge Clk);
    #1;
  endtask

  // One Tick pulse; on return the tick has been taken and its result is
  // visible at the falling edge of the current cycle.
  task automatic tick();
    cyc1(); Tick = 1'b1;
    cyc1(); Tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    Hour = h; Min = m; Sec = s;
  endtask

  // Press a button pattern for a few cycles, expect the result 3 Clk later.
  task automatic press(input bit stp, input bit snz, input string nm, input bit ring,
                       input bit snzg, input bit [1:0] sc);
    int k;
    cyc1(); Stop = stp; Snooze = snz;
    k = cyc;
    expect_at(k + 3, nm, ring, ring, snzg, sc, 1'b0);
    repeat (5) cyc1();
    Stop = 1'b0; Snooze = 1'b0;
    repeat (3) cyc1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state
    repeat (3) cyc1();
    expect_at(cyc + 1, "reset_state", 0, 0, 0, 2'd0, 0);
    cyc1(); cyc1();
    RST = 1'b1;
    cyc1();

    // Match, first-cycle beep, toggling and auto-stop after 60 ticks
    set_time(8'h07, 8'h29, 8'h59);
    tick(); expect_at(cyc, "no_match_0729", 0, 0, 0, 2'd0, 0);
    set_time(8'h07, 8'h30, 8'h00);
    expect_at(cyc + 1, "pre_ring", 0, 0, 0, 2'd0, 0);
    tick(); expect_at(cyc, "ring_rise", 1, 1, 0, 2'd0, 0);
    Sec = 8'h01;
    tick(); expect_at(cyc, "beep_toggle_a", 1, 0, 0, 2'd0, 0);
    tick(); expect_at(cyc, "beep_toggle_b", 1, 1, 0, 2'd0, 0);
    ticks(57); expect_at(cyc, "ring_last_tick", 1, 0, 0, 2'd0, 0);
    tick(); expect_at(cyc, "auto_stop", 0, 0, 0, 2'd0, 0);

    // Stop: 3-cycle latency, no re-trigger with Sec != 00
    Sec = 8'h00;
    tick(); expect_at(cyc, "ring_for_stop", 1, 1, 0, 2'd0, 0);
    Sec = 8'h01;
    tick(); expect_at(cyc, "ring_for_stop_b", 1, 0, 0, 2'd0, 0);
    cyc1(); Stop = 1'b1;
    k = cyc;
    expect_at(k + 2, "stop_latency_2", 1, 0, 0, 2'd0, 0);
    expect_at(k + 3, "stop_latency_3", 0, 0, 0, 2'd0, 0);
    repeat (5) cyc1();
    Stop = 1'b0;
    repeat (3) cyc1();
    Sec = 8'h02;
    tick(); expect_at(cyc, "no_retrigger", 0, 0, 0, 2'd0, 0);

    // Snooze three times, fourth snooze acts as stop
    Sec = 8'h00;
    tick(); expect_at(cyc, "ring_for_snooze", 1, 1, 0, 2'd0, 0);
    Sec = 8'h01;
    for (int i = 1; i <= 3; i++) begin
      press(1'b0, 1'b1, "snooze_enter", 0, 1, 2'(i));
      ticks(299); expect_at(cyc, "snooze_hold", 0, 0, 1, 2'(i), 0);
      tick();     expect_at(cyc, "snooze_wake", 1, 1, 0, 2'(i), 0);
    end
    press(1'b0, 1'b1, "snooze_over_max", 0, 0, 2'd3);
    Sec = 8'h00;
    tick(); expect_at(cyc, "snzcnt_cleared", 1, 1, 0, 2'd0, 0);
    Sec = 8'h01;

    // Stop and Snooze in the same cycle: stop wins
    press(1'b1, 1'b1, "stop_beats_snooze", 0, 0, 2'd0);

    // Snooze ignored while snoozing, EN drop mid-snooze
    Sec = 8'h00;
    tick(); expect_at(cyc, "ring_for_en", 1, 1, 0, 2'd0, 0);
    Sec = 8'h01;
    press(1'b0, 1'b1, "snooze_for_en", 0, 1, 2'd1);
    ticks(5);
    press(1'b0, 1'b1, "snooze_ignored", 0, 1, 2'd1);
    cyc1(); EN = 1'b0;
    k = cyc;
    expect_at(k + 1, "en_drop", 0, 0, 0, 2'd1, 0);
    repeat (3) cyc1();
    EN = 1'b1;

    // 12 h / 24 h compare
    Mode = 1'b1; AlertHour = 8'h06; AlertMin = 8'h00; AlertAPM = 1'b1;
    set_time(8'h06, 8'h00, 8'h00); APM = 1'b0;
    tick(); expect_at(cyc, "12h_apm_mismatch", 0, 0, 0, 2'd1, CHIME_ON);
    APM = 1'b1;
    tick(); expect_at(cyc, "12h_apm_match", 1, 1, 0, 2'd0, 0);
    press(1'b1, 1'b0, "stop_12h", 0, 0, 2'd0);
    Mode = 1'b0; APM = 1'b0;
    tick(); expect_at(cyc, "24h_apm0", 1, 1, 0, 2'd0, 0);
    press(1'b1, 1'b0, "stop_24h", 0, 0, 2'd0);
    APM = 1'b1;
    tick(); expect_at(cyc, "24h_apm1", 1, 1, 0, 2'd0, 0);

    // Asynchronous reset mid-ringing, checked between clock edges
    cyc1(); #2;
    RST = 1'b0;
    #1;
    compare("async_reset", 0, 0, 0, 2'd0, 0);
    cyc1(); cyc1();
    RST = 1'b1;
    cyc1();

    // Hourly chime and alarm precedence
    AlertHour = 8'h07; AlertMin = 8'h30; APM = 1'b0;
    set_time(8'h09, 8'h59, 8'h59);
    tick(); expect_at(cyc, "chime_pre", 0, 0, 0, 2'd0, 0);
    set_time(8'h10, 8'h00, 8'h00);
    tick(); expect_at(cyc, "chime_tick1", 0, 0, 0, 2'd0, CHIME_ON);
    Sec = 8'h01;
    tick(); expect_at(cyc, "chime_tick2", 0, 0, 0, 2'd0, CHIME_ON);
    tick(); expect_at(cyc, "chime_end", 0, 0, 0, 2'd0, 0);
    AlertHour = 8'h10; AlertMin = 8'h00;
    Sec = 8'h00;
    tick(); expect_at(cyc, "alarm_over_chime", 1, 1, 0, 2'd0, 0);

    repeat (5) cyc1();
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
